// File: rtl/io_input_bank.sv
// io_input_bank: memory-mapped bank of NPORTS synchronised input ports.
// Each port passes through a two-flop synchroniser, an optional debounce
// filter and a stable value register. A sticky per-port change flag records
// every accepted value change. The flags are readable as a status word that
// clears on read, and they drive a registered interrupt line.
// Configuration macro: IO_IN_DEBOUNCE_EN. When it is defined, each port is
// debounced over DEBOUNCE_CYCLES stable cycles. When it is undefined, the
// synchronised value is accepted every cycle.
module io_input_bank #(
    parameter int          NPORTS          = 2,
    parameter int          PORT_W          = 4,
    parameter logic [5:0]  BASE_SEL        = 6'b110000,
    parameter int          DEBOUNCE_CYCLES = 4
) (
    input  logic                     io_clk,
    input  logic                     reset,
    input  logic [31:0]              addr,
    input  logic                     io_rd,
    input  logic [NPORTS*PORT_W-1:0] in_port,
    output logic [31:0]              io_read_data,
    output logic                     io_irq
);

    localparam int IW       = NPORTS * PORT_W;
    localparam int BASE_I   = int'(BASE_SEL);
    localparam int STAT_I   = BASE_I + NPORTS;

    // Word select on the CPU data address; only addr[7:2] is decoded.
    logic [31:0] sel_ext;
    logic        status_hit;
    logic        status_clr;
    logic        unused_addr_bits;

    assign sel_ext          = {26'd0, addr[7:2]};
    assign status_hit       = (sel_ext == 32'(STAT_I));
    assign status_clr       = io_rd && status_hit;
    assign unused_addr_bits = ^{addr[31:8], addr[1:0]};

    // Synchroniser, stable value and flag state.
    logic [IW-1:0]     sync1_q, sync1_d;
    logic [IW-1:0]     sync2_q, sync2_d;
    logic [IW-1:0]     port_val_q, port_val_d;
    logic [NPORTS-1:0] chg_pend_q, chg_pend_d;
    logic [NPORTS-1:0] chg_q, chg_d;
    logic              irq_q, irq_d;

    // Two-flop synchroniser on the raw inputs.
    always_comb begin
        sync1_d = in_port;
        sync2_d = sync1_q;
    end

`ifdef IO_IN_DEBOUNCE_EN
    localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Previous-cycle copy of sync2 lets a new candidate value restart the count.
    logic [IW-1:0]                 sync2_prev_q, sync2_prev_d;
    logic [NPORTS-1:0][CNT_W-1:0]  cnt_q, cnt_d;
    logic [NPORTS-1:0][CNT_W-1:0]  cnt_inc;

    // Debounce filter: accept a candidate only after it is stable for DEBOUNCE_CYCLES.
    always_comb begin
        sync2_prev_d = sync2_q;
        port_val_d   = port_val_q;
        cnt_d        = cnt_q;
        cnt_inc      = '0;
        for (int i = 0; i < NPORTS; i++) begin
            if (sync2_q[i*PORT_W +: PORT_W] == port_val_q[i*PORT_W +: PORT_W]) begin
                cnt_d[i] = '0;
            end else begin
                if (sync2_q[i*PORT_W +: PORT_W] != sync2_prev_q[i*PORT_W +: PORT_W]) begin
                    cnt_inc[i] = CNT_ONE;
                end else if (cnt_q[i] >= CNT_MAX) begin
                    cnt_inc[i] = CNT_MAX;
                end else begin
                    cnt_inc[i] = cnt_q[i] + CNT_ONE;
                end
                if (cnt_inc[i] == CNT_MAX) begin
                    port_val_d[i*PORT_W +: PORT_W] = sync2_q[i*PORT_W +: PORT_W];
                    cnt_d[i]                       = '0;
                end else begin
                    cnt_d[i] = cnt_inc[i];
                end
            end
        end
    end

    // Debounce counter and previous-sample registers.
    always_ff @(posedge io_clk or posedge reset) begin
        if (reset) begin
            sync2_prev_q <= '0;
            cnt_q        <= '0;
        end else begin
            sync2_prev_q <= sync2_prev_d;
            cnt_q        <= cnt_d;
        end
    end
`else
    localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;

    // Without debounce the synchronised value is accepted every cycle.
    always_comb begin
        port_val_d = sync2_q;
    end
`endif

    // Change detection: an accepted value differing from the old one raises a
    // pending bit that becomes a sticky flag on the following edge. A status
    // read clears the flags it returned, but a flag being set at that edge wins.
    always_comb begin
        chg_pend_d = '0;
        for (int i = 0; i < NPORTS; i++) begin
            chg_pend_d[i] = (port_val_d[i*PORT_W +: PORT_W] != port_val_q[i*PORT_W +: PORT_W]);
        end
        chg_d = (status_clr ? '0 : chg_q) | chg_pend_q;
        irq_d = |chg_q;
    end

    // State registers for the synchroniser, stable values, flags and interrupt.
    always_ff @(posedge io_clk or posedge reset) begin
        if (reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            port_val_q <= '0;
            chg_pend_q <= '0;
            chg_q      <= '0;
            irq_q      <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            port_val_q <= port_val_d;
            chg_pend_q <= chg_pend_d;
            chg_q      <= chg_d;
            irq_q      <= irq_d;
        end
    end

    // Combinational read mux. Unmapped selects return zero, and no latch is
    // needed because every path starts from zero.
    always_comb begin
        io_read_data = '0;
        for (int i = 0; i < NPORTS; i++) begin
            if (sel_ext == 32'(BASE_I + i)) begin
                io_read_data[PORT_W-1:0] = port_val_q[i*PORT_W +: PORT_W];
            end
        end
        if (status_hit) begin
            io_read_data[NPORTS-1:0] = chg_q;
        end
    end

    assign io_irq = irq_q;

endmodule

// File: doc/io_input_bank.md
# io_input_bank

Parametrised memory-mapped input port bank for the pipelined CPU's I/O space. It synchronises, optionally debounces, and registers NPORTS external input ports, and returns any port or a change-status word on a combinational read path selected by addr[7:2]. Sticky change flags and an interrupt line let software poll or be notified of switch/key activity. Reads of unmapped selects return zero; no latched read mux.

## Interface
- NPORTS, 2, number of input ports (1..32)
- PORT_W, 4, width of each port in bits (1..32); zero-extended to 32 on read
- BASE_SEL, 6'b110000, addr[7:2] value of port 0; port i at BASE_SEL+i; status word at BASE_SEL+NPORTS; BASE_SEL+NPORTS ≤ 63
- DEBOUNCE_CYCLES, 4, consecutive stable cycles required before a port value is accepted (≥1; used only with IO_IN_DEBOUNCE_EN)

- io_clk  input  1  single clock; all state on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- addr  input  32  CPU data address; only addr[7:2] decoded
- io_rd  input  1  read strobe, high for the cycle the CPU samples io_read_data
- in_port  input  NPORTS*PORT_W  raw asynchronous inputs, port i at bits [i*PORT_W +: PORT_W]
- io_read_data  output  32  read data, combinational from addr and registered state
- io_irq  output  1  registered; high while any change flag is set

## Operation
- Per port: two-flop synchroniser sync1→sync2, then a stable register port_val[i].
- With debounce: per-port counter cnt[i], width clog2(DEBOUNCE_CYCLES+1). If sync2 == port_val: cnt←0. Else if sync2 differs from its previous-cycle value: cnt←1. Else cnt←cnt+1, saturating at DEBOUNCE_CYCLES. When cnt reaches DEBOUNCE_CYCLES, port_val←sync2 and cnt←0.
- Glitch shorter than DEBOUNCE_CYCLES: port_val unchanged, no flag.
- Change flag chg[i] is set in the cycle after port_val[i] updates to a different value (edge in either direction).
- Read decode on sel = addr[7:2]: sel == BASE_SEL+i → {zeros, port_val[i]}; sel == BASE_SEL+NPORTS → {zeros, chg[NPORTS-1:0]}; anything else → 32'h0.
- Read-to-clear: io_rd high with sel == status address clears, at that clock edge, exactly the chg bits returned. A bit being set at the same edge stays set (set wins).
- Port reads have no side effects. io_rd with an unmapped sel has no effect.
- io_irq ← |chg, registered.

## Timing
- Reset (asynchronous assert, deassert synchronous to io_clk by the system): sync1, sync2, port_val, cnt, chg = 0; io_irq = 0; io_read_data = 0 for every select.
- Input step held steady, debounce on: port_val updates at edge 2+DEBOUNCE_CYCLES after the first sampling edge. chg is set one edge later. io_irq rises one edge after chg.
- Debounce off: port_val updates at edge 3 after the sampling edge. chg is set at edge 4 and io_irq at edge 5.
- io_read_data is valid in the same cycle addr is presented; no wait states.
- Reset mid-debounce discards the pending count; after release, all ports re-acquire from zero.
- Simultaneous changes on several ports set all corresponding chg bits in the same cycle.

## Configuration
- IO_IN_DEBOUNCE_EN defined: debounce counters are instantiated as described, and DEBOUNCE_CYCLES is honoured.
- IO_IN_DEBOUNCE_EN undefined: no counters; port_val←sync2 every cycle, and DEBOUNCE_CYCLES is ignored. Decode, flags and irq are identical.

## Test plan
Default parameters, debounce on.
- Reset with in_port = 8'hA5 → all reads 0, io_irq = 0. After release and ≥8 cycles: read sel 6'b110000 = 32'h5, sel 6'b110001 = 32'hA, status (6'b110010) = 32'h3.
- Status read with io_rd = 1 → returns 32'h3, following read returns 32'h0, and io_irq falls one cycle after the clear.
- Port 0 glitch 4'h5→4'h0 for 3 cycles, then back → port_val stays 5 and status stays 0.
- Port 1 step 4'hA→4'h3 held → read sel 6'b110001 changes to 32'h3 exactly at edge 6, status bit1 set at edge 7, io_irq = 1 at edge 8.
- Status clear in the same cycle that port 0 sets its flag → returned bit0 = 0 and bit0 remains set afterwards. Read of sel 6'b000111 → 32'h0 with no state change.
- IO_IN_DEBOUNCE_EN undefined: 1-cycle glitch on port 0 → propagates to port_val after 3 edges and sets chg[0].
